// File: rtl/bcd_serial_add_sub.sv
// Digit-serial BCD adder/subtractor, least-significant digit first.
// Subtraction adds the 10's complement of B; a negative result gets a second re-complement pass.
module bcd_serial_add_sub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   Result,
    output logic                  Cout,
    output logic                  Neg
);
    localparam int IW = $clog2(DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_FIX} state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [4*DIGITS-1:0] result_q, result_d;
    logic                cout_q, cout_d;
    logic                neg_q, neg_d;
    logic                carry_q, carry_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] a_q, a_d;
    logic [4*DIGITS-1:0] b_q, b_d;
    logic                op_q, op_d;

    logic [3:0] a_digs [DIGITS];
    logic [3:0] b_digs [DIGITS];
    logic [3:0] r_digs [DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign a_digs[gi] = a_q[4*gi +: 4];
            assign b_digs[gi] = b_q[4*gi +: 4];
            assign r_digs[gi] = result_q[4*gi +: 4];
        end
    endgenerate

    logic       last_dig;
    logic [3:0] x_dig, y_dig, sum_dig;
    logic [4:0] raw_sum;
    logic       c_out;

    assign last_dig = (idx_q == IW'(DIGITS - 1));

    // Shared digit adder: ADD uses A_i + (B_i or 9-B_i); FIX uses (9-Result_i) + 0.
    always_comb begin
        x_dig = 4'd0;
        y_dig = 4'd0;
        if (state_q == S_FIX) begin
            x_dig = 4'd9 - r_digs[idx_q];
        end else begin
            x_dig = a_digs[idx_q];
            y_dig = op_q ? (4'd9 - b_digs[idx_q]) : b_digs[idx_q];
        end
        raw_sum = {1'b0, x_dig} + {1'b0, y_dig} + {4'd0, carry_q};
        if (raw_sum > 5'd9) begin
            sum_dig = raw_sum[3:0] + 4'd6;
            c_out   = 1'b1;
        end else begin
            sum_dig = raw_sum[3:0];
            c_out   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADD;
            S_ADD:   if (last_dig) state_d = (op_q && !c_out) ? S_FIX : S_IDLE;
            S_FIX:   if (last_dig) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        cout_d   = cout_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        done_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    op_d     = op;
                    idx_d    = '0;
                    carry_d  = op;
                    result_d = '0;
                    cout_d   = 1'b0;
                    neg_d    = 1'b0;
                end
            end
            S_ADD, S_FIX: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (IW'(i) == idx_q) result_d[4*i +: 4] = sum_dig;
                end
                carry_d = c_out;
                idx_d   = idx_q + 1'b1;
                if (last_dig) begin
                    idx_d = '0;
                    if (state_q == S_FIX) begin
                        done_d  = 1'b1;
                        carry_d = 1'b0;
                    end else if (op_q && !c_out) begin
                        // Borrow out: magnitude is the 10's complement of what we just wrote.
                        carry_d = 1'b1;
                        cout_d  = 1'b0;
                        neg_d   = 1'b1;
                    end else begin
                        cout_d = c_out;
                        neg_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;
    assign Cout   = cout_q;
    assign Neg    = neg_q;
endmodule

// File: tb/tb_bcd_serial_add_sub.sv
// Directed bench for bcd_serial_add_sub with DIGITS=4 and hand-computed expectations.
module tb_bcd_serial_add_sub;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_i;
    logic [15:0] a_i, b_i;
    logic        busy, done, cout, neg;
    logic [15:0] result;

    int total = 0;
    int bad   = 0;

    bcd_serial_add_sub #(.DIGITS(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op_i),
        .A      (a_i),
        .B      (b_i),
        .busy   (busy),
        .done   (done),
        .Result (result),
        .Cout   (cout),
        .Neg    (neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issues one operation starting at the next falling edge; returns right after done is seen,
    // so consecutive calls place the next start in the done cycle.
    task automatic run_op(input string name, input logic o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] er, input logic ec,
                          input logic en, input int lat, input bit poke);
        int n;
        bit seen, busy_drop;
        @(negedge clk);
        op_i = o; a_i = a; b_i = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, " busy_after_start"}, busy, 1);
        check({name, " done_low_after_start"}, done, 0);
        n = 0; seen = 0; busy_drop = 0;
        while (n < 30 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 1) begin
                start = 1'b1; op_i = 1'b1; a_i = 16'h1111; b_i = 16'h9999;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1;
            else if (!busy) busy_drop = 1;
        end
        check({name, " latency"}, n, lat);
        check({name, " busy_held"}, busy_drop, 0);
        check({name, " result"}, result, er);
        check({name, " cout"}, cout, ec);
        check({name, " neg"}, neg, en);
        check({name, " busy_at_done"}, busy, 0);
        $display("op %s: op=%0d A=%h B=%h -> Result=%h Cout=%0d Neg=%0d latency=%0d",
                 name, o, a, b, result, cout, neg, n);
    endtask

    initial begin
        bit done_seen;
        reset = 1'b1; start = 1'b0; op_i = 1'b0; a_i = '0; b_i = '0;
        #12;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset cout", cout, 0);
        check("reset neg", neg, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("add_1234_5678", 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 4, 1'b0);
        run_op("add_9999_0001", 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 4, 1'b0);
        run_op("add_0000_0000", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
        run_op("sub_5000_1234", 1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0, 4, 1'b0);
        run_op("sub_0000_0000", 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 4, 1'b0);
        run_op("sub_1234_5000", 1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b0, 1'b1, 8, 1'b0);
        run_op("sub_0000_0001", 1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b1, 8, 1'b0);
        run_op("add_ignored_start", 1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 4, 1'b1);

        // Reset in the middle of an addition.
        @(negedge clk);
        op_i = 1'b0; a_i = 16'h1234; b_i = 16'h5678; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midreset partial_digit0", result, 16'h0002);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset result", result, 0);
        check("midreset cout", cout, 0);
        check("midreset neg", neg, 0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1;
        end
        check("midreset no_done", done_seen, 0);
        check("midreset idle", busy, 0);
        $display("op midreset: abandoned 1234+5678, Result=%h busy=%0d", result, busy);

        run_op("add_after_reset", 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_serial_add_sub.md
# bcd_serial_add_sub

Sequential multi-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first. It is the consumer of the BCD 9's complementor: in subtract mode each B digit passes through the complementor before the digit adder, with carry-in forced to 1, so the block forms A + 10's complement of B. When a subtraction result is negative, the block runs a second serial pass to re-complement the result. It returns sign plus magnitude.

## Interface
Parameters:
- DIGITS, default 4: number of BCD digits per operand. Must be at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = A + B, 1 = A − B; latched with start
- A  in  4*DIGITS  operand A; digit i is A[4i+3:4i]; latched with start
- B  in  4*DIGITS  operand B, same packing; latched with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when Result, Cout and Neg become valid
- Result  out  4*DIGITS  BCD result (magnitude in subtract mode); held until the next accepted start
- Cout  out  1  add: decimal overflow; sub: no-borrow (1 when A ≥ B)
- Neg  out  1  sub only: 1 when A < B; always 0 in add mode

## Operation
- States: IDLE, ADD, FIX.
- In IDLE, start=1 does the following:
  - latch A, B and op;
  - set the digit index to 0 and carry to op;
  - clear Result;
  - go to ADD.
- ADD digit step, for digit i:
  - b' = op ? 9 − B_i : B_i (9's complement);
  - s = A_i + b' + carry, 5 bits;
  - if s > 9: digit = (s + 6)[3:0] and carry = 1; otherwise digit = s and carry = 0;
  - write the digit to Result_i and increment the index.
- After digit DIGITS−1:
  - op=0: Cout = final carry, Neg = 0, go to IDLE and pulse done.
  - op=1 with final carry 1: Cout = 1, Neg = 0, go to IDLE and pulse done.
  - op=1 with final carry 0: Cout = 0, Neg = 1, reset the index to 0 and carry to 1, go to FIX.
- FIX digit step, for digit i: s = (9 − Result_i) + carry, with the same > 9 correction as ADD; overwrite Result_i. After the last digit, go to IDLE and pulse done. The final carry of FIX is discarded.
- start while busy: ignored; the latched operands do not change.
- Non-BCD input digits (> 9): result unspecified. The FSM still finishes in the specified number of cycles and never hangs.
- busy = (state ≠ IDLE). It is registered together with the state.

## Timing
- Reset values: state IDLE, busy 0, done 0, Result 0, Cout 0, Neg 0, internal carry and index 0. Reset takes effect immediately (asynchronous) and releases synchronously.
- Reset mid-operation: the operation is abandoned, all outputs return to their reset values, and done is not pulsed.
- Edge numbering: start accepted at rising edge k.
  - busy = 1 after edge k.
  - Digit i is computed at edge k+1+i.
- Addition, or non-negative subtraction:
  - last digit at edge k+DIGITS;
  - done = 1 and busy = 0 during the cycle after edge k+DIGITS;
  - latency is DIGITS cycles.
- Negative subtraction:
  - FIX digit i is computed at edge k+DIGITS+1+i;
  - done follows edge k+2·DIGITS;
  - latency is 2·DIGITS cycles. Cout and Neg are valid from the cycle done is high.
- done is high for exactly one cycle. Result, Cout and Neg hold until the edge that accepts the next start.
- A start asserted in the same cycle as done is accepted, because the state is already IDLE. This allows back-to-back operations with no gap.
- During ADD and FIX, Result digits update one per cycle. Partial values are visible but not valid until done.

## Test plan
All scenarios use DIGITS=4.
- Add 1234 + 5678 → Result 6912, Cout 0, Neg 0; done in the cycle after edge k+4.
- Add 9999 + 0001 → Result 0000, Cout 1, Neg 0. Add 0000 + 0000 → 0000, Cout 0.
- Sub 5000 − 1234 → Result 3766, Cout 1, Neg 0; done after edge k+4. Sub 0000 − 0000 → 0000, Cout 1, Neg 0.
- Sub 1234 − 5000 → Result 3766, Cout 0, Neg 1; done after edge k+8; busy stays high through the FIX pass. Sub 0000 − 0001 → 0001, Neg 1.
- Assert start with new operands during ADD → ignored; the first result is unchanged. Issue a new start in the done cycle → accepted, and its done arrives 4 cycles later.
- Assert reset at the second ADD edge of 1234 + 5678 → outputs immediately 0, no done pulse, state IDLE. A following start with 0001 + 0002 → 0003.
